// File: rtl/asu_ddr5_read_fsm.sv
// DDR5 PHY read-path control: waits the read latency, locks onto the DRAM read
// preamble, captures the DQ burst and checks the trailing CRC word.
module asu_ddr5_read_fsm #(
  parameter int pDRAM_SIZE = 4,
  parameter int pTIMEOUT   = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      rd_en_i,
  input  logic [5:0]                rd_latency_i,
  input  logic [1:0]                burstlength_i,
  input  logic                      crc_check_i,
  input  logic                      dqs_valid_i,
  input  logic [1:0]                dqs_i,
  input  logic [2*pDRAM_SIZE-1:0]   dq_i,
  input  logic [2*pDRAM_SIZE-1:0]   crc_code_i,
  output logic [2*pDRAM_SIZE-1:0]   rddata_o,
  output logic                      rddata_valid_o,
  output logic [2*pDRAM_SIZE-1:0]   crc_data_o,
  output logic                      crc_enable_o,
  output logic                      crc_error_o,
  output logic                      timeout_error_o,
  output logic                      rd_done_o,
  output logic                      rd_overrun_o,
  output logic                      busy_o
);

  localparam int DATA_W = 2 * pDRAM_SIZE;
  localparam int TMO_W  = $clog2(pTIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(pTIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LATENCY, PRE_WAIT, PRE_TGL, DATA, PAD, CRC, POSTAMBLE
  } state_t;

  state_t              state_q;
  logic [5:0]          lat_q;
  logic [2:0]          beat_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                bl8_q, crc_chk_q, err_q;
  logic [DATA_W-1:0]   crc_rx_q, rddata_q, crc_data_q;
  logic                rddata_valid_q, crc_enable_q, crc_error_q;
  logic                timeout_q, rd_done_q, rd_overrun_q;

  function automatic logic last_beat(input logic [2:0] beat, input logic bl8);
    return bl8 ? (beat == 3'd3) : (beat == 3'd7);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      lat_q          <= '0;
      beat_q         <= '0;
      tmo_q          <= '0;
      bl8_q          <= 1'b0;
      crc_chk_q      <= 1'b0;
      err_q          <= 1'b0;
      crc_rx_q       <= '0;
      rddata_q       <= '0;
      crc_data_q     <= '0;
      rddata_valid_q <= 1'b0;
      crc_enable_q   <= 1'b0;
      crc_error_q    <= 1'b0;
      timeout_q      <= 1'b0;
      rd_done_q      <= 1'b0;
      rd_overrun_q   <= 1'b0;
    end else if (!enable_i) begin
      rddata_valid_q <= 1'b0;
      crc_enable_q   <= 1'b0;
      crc_error_q    <= 1'b0;
      timeout_q      <= 1'b0;
      rd_done_q      <= 1'b0;
      rd_overrun_q   <= 1'b0;
    end else begin
      rddata_valid_q <= 1'b0;
      crc_enable_q   <= 1'b0;
      crc_error_q    <= 1'b0;
      timeout_q      <= 1'b0;
      rd_done_q      <= 1'b0;
      rd_overrun_q   <= rd_en_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (rd_en_i) begin
            bl8_q     <= (burstlength_i == 2'b01);
            crc_chk_q <= crc_check_i;
            lat_q     <= rd_latency_i;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            state_q   <= (rd_latency_i == 6'd0) ? PRE_WAIT : LATENCY;
          end
        end
        LATENCY: begin
          lat_q <= lat_q - 6'd1;
          if (lat_q == 6'd1) state_q <= PRE_WAIT;
        end
        PRE_WAIT: begin
          if (tmo_q == TMO_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (dqs_valid_i && dqs_i == 2'b00) state_q <= PRE_TGL;
          end
        end
        // A valid toggle on the final search cycle still wins over the timeout.
        PRE_TGL: begin
          if (dqs_valid_i && dqs_i == 2'b10) begin
            state_q <= DATA;
            beat_q  <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!(dqs_valid_i && dqs_i == 2'b00)) state_q <= PRE_WAIT;
          end
        end
        DATA: begin
          rddata_q       <= dq_i;
          crc_data_q     <= dq_i;
          rddata_valid_q <= 1'b1;
          crc_enable_q   <= 1'b1;
          beat_q         <= beat_q + 3'd1;
          if (last_beat(beat_q, bl8_q)) begin
            beat_q  <= '0;
            state_q <= !crc_chk_q ? POSTAMBLE : (bl8_q ? PAD : CRC);
          end
        end
        // BL8 bursts carry an all-ones pad in place of the missing beats.
        PAD: begin
          crc_data_q   <= dq_i;
          crc_enable_q <= 1'b1;
          if (dq_i != {DATA_W{1'b1}}) err_q <= 1'b1;
          beat_q <= beat_q + 3'd1;
          if (last_beat(beat_q, 1'b1)) state_q <= CRC;
        end
        CRC: begin
          crc_rx_q <= dq_i;
          state_q  <= POSTAMBLE;
        end
        POSTAMBLE: begin
          state_q     <= IDLE;
          rd_done_q   <= 1'b1;
          crc_error_q <= err_q || (crc_chk_q && (crc_rx_q != crc_code_i));
          err_q       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rddata_o        = rddata_q;
  assign rddata_valid_o  = rddata_valid_q;
  assign crc_data_o      = crc_data_q;
  assign crc_enable_o    = crc_enable_q;
  assign crc_error_o     = crc_error_q;
  assign timeout_error_o = timeout_q;
  assign rd_done_o       = rd_done_q;
  assign rd_overrun_o    = rd_overrun_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_asu_ddr5_read_fsm.sv
// Bench for asu_ddr5_read_fsm: directed and randomized read bursts checked
// cycle by cycle against a burst-level timeline model.
module tb_asu_ddr5_read_fsm;

  localparam int DW  = 8;
  localparam int TMO = 15;
  localparam int N   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, rd_en, crc_chk, dqsv;
  logic [5:0]    rd_lat;
  logic [1:0]    bl, dqs;
  logic [DW-1:0] dq, code;
  logic [DW-1:0] rddata, crc_data;
  logic          rddata_valid, crc_en, crc_err, tmo_err, done, ovr, busy;

  asu_ddr5_read_fsm #(.pDRAM_SIZE(DW/2), .pTIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .rd_en_i(rd_en),
    .rd_latency_i(rd_lat), .burstlength_i(bl), .crc_check_i(crc_chk),
    .dqs_valid_i(dqsv), .dqs_i(dqs), .dq_i(dq), .crc_code_i(code),
    .rddata_o(rddata), .rddata_valid_o(rddata_valid), .crc_data_o(crc_data),
    .crc_enable_o(crc_en), .crc_error_o(crc_err), .timeout_error_o(tmo_err),
    .rd_done_o(done), .rd_overrun_o(ovr), .busy_o(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // per-cycle stimulus, offset 0 = cycle the read command is presented
  logic          s_rst [N];
  logic          s_en  [N];
  logic          s_rden[N];
  logic          s_dqsv[N];
  logic [1:0]    s_dqs [N];
  logic [DW-1:0] s_dq  [N];
  logic [DW-1:0] s_code[N];
  logic [5:0]    c_lat;
  logic [1:0]    c_bl;
  logic          c_crc;
  int            m_lat;

  // status bits: {valid, crc_en, done, crc_err, timeout, overrun, busy}
  logic [6:0]    e_st[N], o_st[N];
  logic [DW-1:0] e_dat[N], e_cdat[N], o_dat[N], o_cdat[N];
  int            e_fin;

  task automatic clear_stim();
    for (int k = 0; k < N; k++) begin
      s_rst[k] = 1'b0; s_en[k] = 1'b1; s_rden[k] = 1'b0; s_dqsv[k] = 1'b0;
      s_dqs[k] = 2'($urandom); s_dq[k] = DW'($urandom); s_code[k] = DW'($urandom);
    end
    s_rden[0] = 1'b1;
  endtask

  // Burst-level timeline: preamble search window, beat positions, CRC compare.
  task automatic build_model();
    int p, d, nb, c, q;
    logic bl8, pad, perr, tgl;
    for (int k = 0; k < N; k++) begin e_st[k] = '0; e_dat[k] = '0; e_cdat[k] = '0; end
    p = m_lat + 1; bl8 = (c_bl == 2'b01); nb = bl8 ? 4 : 8; pad = bl8 && c_crc;
    d = -1; tgl = 1'b0;
    for (int k = p; k < p + TMO; k++) begin
      if (tgl && s_dqsv[k] && s_dqs[k] == 2'b10) begin d = k + 1; break; end
      tgl = s_dqsv[k] && (s_dqs[k] == 2'b00);
    end
    if (d < 0) begin
      e_fin = p + TMO;
      e_st[e_fin][2] = 1'b1;
    end else begin
      for (int i = 0; i < nb; i++) begin
        e_st[d+1+i][6] = 1'b1; e_st[d+1+i][5] = 1'b1;
        e_dat[d+1+i] = s_dq[d+i]; e_cdat[d+1+i] = s_dq[d+i];
      end
      perr = 1'b0;
      if (pad) for (int i = 0; i < 4; i++) begin
        e_st[d+nb+1+i][5] = 1'b1; e_cdat[d+nb+1+i] = s_dq[d+nb+i];
        if (s_dq[d+nb+i] != 8'hFF) perr = 1'b1;
      end
      c = d + nb + (pad ? 4 : 0);
      q = c_crc ? c + 1 : d + nb;
      e_fin = q + 1;
      e_st[e_fin][4] = 1'b1;
      e_st[e_fin][3] = perr || (c_crc && s_dq[c] != s_code[q]);
    end
    for (int k = 1; k < e_fin; k++) begin
      e_st[k][0] = 1'b1;
      if (s_rden[k] && s_en[k]) e_st[k+1][1] = 1'b1;
    end
  endtask

  task automatic run_stim(input int len);
    for (int k = 0; k < len; k++) begin
      rst = s_rst[k]; en = s_en[k]; rd_en = s_rden[k];
      rd_lat  = (k == 0) ? c_lat : 6'($urandom_range(0, 63));
      bl      = (k == 0) ? c_bl  : 2'($urandom);
      crc_chk = (k == 0) ? c_crc : 1'($urandom);
      dqsv = s_dqsv[k]; dqs = s_dqs[k]; dq = s_dq[k]; code = s_code[k];
      @(negedge clk);
      o_st[k]   = {rddata_valid, crc_en, done, crc_err, tmo_err, ovr, busy};
      o_dat[k]  = rddata;
      o_cdat[k] = crc_data;
      @(posedge clk); #1;
    end
    rst = 1'b0; en = 1'b1; rd_en = 1'b0; dqsv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rd_en = 1'b1; rd_lat = 6'd0; bl = 2'b10; crc_chk = 1'b1;
    dqsv = 1'b1; dqs = 2'b00; dq = 8'hA5; code = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({rddata_valid, crc_en, done, crc_err, tmo_err, ovr, busy, rddata, crc_data} !== '0) begin
      n_err++; $display("FAIL reset_held outputs=%b required all zero",
        {rddata_valid, crc_en, done, crc_err, tmo_err, ovr, busy, rddata, crc_data});
    end
    rst = 1'b0; rd_en = 1'b0; dqsv = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if ({rddata_valid, crc_en, done, crc_err, tmo_err, ovr, busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_release status=%b required 0000000",
        {rddata_valid, crc_en, done, crc_err, tmo_err, ovr, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bl16_nocrc();
    clear_stim();
    c_lat = 6'd3; m_lat = 3; c_bl = 2'b10; c_crc = 1'b0;
    s_dqsv[4] = 1'b1; s_dqs[4] = 2'b00; s_dqsv[5] = 1'b1; s_dqs[5] = 2'b10;
    build_model(); run_stim(e_fin + 3);
    for (int k = 0; k < e_fin + 3; k++) begin
      n_vec++;
      if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL bl16 status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
      if (e_st[k][6]) begin n_vec++; if (o_dat[k] !== e_dat[k]) begin n_err++; $display("FAIL bl16 rddata cyc %0d got %h want %h", k, o_dat[k], e_dat[k]); end end
    end
    n_vec++;
    if (o_st[15][4] !== 1'b1 || o_st[7][6] !== 1'b1 || o_st[14][6] !== 1'b1 || o_st[15][6] !== 1'b0 || o_dat[7] !== s_dq[6]) begin
      n_err++; $display("FAIL bl16 timing done15=%b v7=%b v14=%b v15=%b d7=%h want 1 1 1 0 %h",
        o_st[15][4], o_st[7][6], o_st[14][6], o_st[15][6], o_dat[7], s_dq[6]);
    end
  endtask

  task automatic test_bl16_crc(input logic flip);
    clear_stim();
    c_lat = 6'd3; m_lat = 3; c_bl = 2'b00; c_crc = 1'b1;
    s_dqsv[4] = 1'b1; s_dqs[4] = 2'b00; s_dqsv[5] = 1'b1; s_dqs[5] = 2'b10;
    s_code[15] = s_dq[14] ^ (flip ? 8'h10 : 8'h00);
    build_model(); run_stim(e_fin + 3);
    for (int k = 0; k < e_fin + 3; k++) begin
      n_vec++;
      if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL bl16crc status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
      if (e_st[k][5]) begin n_vec++; if (o_cdat[k] !== e_cdat[k]) begin n_err++; $display("FAIL bl16crc crcdata cyc %0d got %h want %h", k, o_cdat[k], e_cdat[k]); end end
    end
    n_vec++;
    if (o_st[16][4] !== 1'b1 || o_st[16][3] !== flip || o_st[15][5] !== 1'b0) begin
      n_err++; $display("FAIL bl16crc done16=%b err16=%b crcen15=%b want 1 %b 0", o_st[16][4], o_st[16][3], o_st[15][5], flip);
    end
  endtask

  task automatic test_bl8_crc_pad(input logic bad);
    int nv, nc;
    clear_stim();
    c_lat = 6'd3; m_lat = 3; c_bl = 2'b01; c_crc = 1'b1;
    s_dqsv[4] = 1'b1; s_dqs[4] = 2'b00; s_dqsv[5] = 1'b1; s_dqs[5] = 2'b10;
    for (int k = 10; k < 14; k++) s_dq[k] = 8'hFF;
    if (bad) s_dq[12] = 8'hFE;
    s_code[15] = s_dq[14];
    build_model(); run_stim(e_fin + 3);
    nv = 0; nc = 0;
    for (int k = 0; k < e_fin + 3; k++) begin
      nv += int'(o_st[k][6]); nc += int'(o_st[k][5]);
      n_vec++;
      if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL bl8pad status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
      if (e_st[k][5]) begin n_vec++; if (o_cdat[k] !== e_cdat[k]) begin n_err++; $display("FAIL bl8pad crcdata cyc %0d got %h want %h", k, o_cdat[k], e_cdat[k]); end end
    end
    n_vec++;
    if (nv != 4 || nc != 8 || o_st[16][4] !== 1'b1 || o_st[16][3] !== bad) begin
      n_err++; $display("FAIL bl8pad counts valid=%0d crcen=%0d done16=%b err16=%b want 4 8 1 %b", nv, nc, o_st[16][4], o_st[16][3], bad);
    end
  endtask

  task automatic test_timeout();
    clear_stim();
    c_lat = 6'd2; m_lat = 2; c_bl = 2'b10; c_crc = 1'b0;
    build_model(); run_stim(e_fin + 3);
    for (int k = 0; k < e_fin + 3; k++) begin
      n_vec++;
      if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL timeout status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
    end
    n_vec++;
    if (o_st[18][2] !== 1'b1 || o_st[17][2] !== 1'b0 || o_st[17][0] !== 1'b1 || o_st[18][0] !== 1'b0 || o_st[18][4] !== 1'b0) begin
      n_err++; $display("FAIL timeout pulse t18=%b t17=%b busy17=%b busy18=%b done18=%b want 1 0 1 0 0",
        o_st[18][2], o_st[17][2], o_st[17][0], o_st[18][0], o_st[18][4]);
    end
  endtask

  task automatic test_false_start_overrun();
    clear_stim();
    c_lat = 6'd1; m_lat = 1; c_bl = 2'b11; c_crc = 1'b0;
    s_dqsv[2] = 1; s_dqs[2] = 2'b00; s_dqsv[3] = 1; s_dqs[3] = 2'b01;
    s_dqsv[4] = 1; s_dqs[4] = 2'b00; s_dqsv[5] = 1; s_dqs[5] = 2'b00;
    s_dqsv[6] = 1; s_dqs[6] = 2'b10;
    s_rden[10] = 1'b1;
    build_model(); run_stim(e_fin + 3);
    for (int k = 0; k < e_fin + 3; k++) begin
      n_vec++;
      if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL falsestart status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
      if (e_st[k][6]) begin n_vec++; if (o_dat[k] !== e_dat[k]) begin n_err++; $display("FAIL falsestart rddata cyc %0d got %h want %h", k, o_dat[k], e_dat[k]); end end
    end
    n_vec++;
    if (o_st[7][6] !== 1'b0 || o_st[8][6] !== 1'b1 || o_dat[8] !== s_dq[7] || o_st[11][1] !== 1'b1 || o_st[16][4] !== 1'b1) begin
      n_err++; $display("FAIL falsestart timing v7=%b v8=%b d8=%h ovr11=%b done16=%b want 0 1 %h 1 1",
        o_st[7][6], o_st[8][6], o_dat[8], o_st[11][1], o_st[16][4], s_dq[7]);
    end
  endtask

  task automatic test_enable_hold();
    clear_stim();
    c_lat = 6'd6; m_lat = 9; c_bl = 2'b10; c_crc = 1'b0;
    s_en[2] = 1'b0; s_en[3] = 1'b0; s_en[4] = 1'b0; s_rden[3] = 1'b1;
    s_dqsv[10] = 1; s_dqs[10] = 2'b00; s_dqsv[11] = 1; s_dqs[11] = 2'b10;
    build_model(); run_stim(e_fin + 3);
    for (int k = 0; k < e_fin + 3; k++) begin
      n_vec++;
      if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL enable status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
      if (e_st[k][6]) begin n_vec++; if (o_dat[k] !== e_dat[k]) begin n_err++; $display("FAIL enable rddata cyc %0d got %h want %h", k, o_dat[k], e_dat[k]); end end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_stim();
    c_lat = 6'd0; m_lat = 0; c_bl = 2'b10; c_crc = 1'b1;
    s_dqsv[1] = 1; s_dqs[1] = 2'b00; s_dqsv[2] = 1; s_dqs[2] = 2'b10;
    s_rst[5] = 1'b1;
    build_model(); run_stim(9);
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (k <= 5) begin
        if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL rstmid status cyc %0d got %b want %b", k, o_st[k], e_st[k]); end
      end else if ({o_st[k], o_dat[k], o_cdat[k]} !== '0) begin
        n_err++; $display("FAIL rstmid after_reset cyc %0d got %b/%h/%h want all zero", k, o_st[k], o_dat[k], o_cdat[k]);
      end
    end
  endtask

  task automatic test_random(input int ntx);
    logic quiet;
    for (int t = 0; t < ntx; t++) begin
      clear_stim();
      c_lat = 6'($urandom_range(0, 12)); m_lat = int'(c_lat);
      c_bl = 2'($urandom); c_crc = 1'($urandom);
      quiet = ($urandom_range(0, 7) == 0);
      for (int k = 1; k < N; k++) begin
        int r;
        if ($urandom_range(0, 1) == 0) s_dq[k] = 8'hFF;
        if ($urandom_range(0, 1) == 0) s_code[k] = s_dq[k-1];
        r = $urandom_range(0, 9);
        s_dqsv[k] = !quiet && (r >= 2);
        s_dqs[k]  = (r <= 5) ? 2'b00 : (r <= 8) ? 2'b10 : 2'($urandom_range(1, 3));
      end
      build_model();
      if ($urandom_range(0, 2) == 0) begin
        s_rden[$urandom_range(1, e_fin - 1)] = 1'b1;
        build_model();
      end
      run_stim(e_fin + 3);
      for (int k = 0; k < e_fin + 3; k++) begin
        n_vec++;
        if (o_st[k] !== e_st[k]) begin n_err++; $display("FAIL random tx %0d status cyc %0d got %b want %b", t, k, o_st[k], e_st[k]); end
        if (e_st[k][6]) begin n_vec++; if (o_dat[k] !== e_dat[k]) begin n_err++; $display("FAIL random tx %0d rddata cyc %0d got %h want %h", t, k, o_dat[k], e_dat[k]); end end
        if (e_st[k][5]) begin n_vec++; if (o_cdat[k] !== e_cdat[k]) begin n_err++; $display("FAIL random tx %0d crcdata cyc %0d got %h want %h", t, k, o_cdat[k], e_cdat[k]); end end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rd_en = 1'b0; rd_lat = '0; bl = '0; crc_chk = 1'b0;
    dqsv = 1'b0; dqs = '0; dq = '0; code = '0;
    test_reset();
    test_bl16_nocrc();
    test_bl16_crc(1'b0);
    test_bl16_crc(1'b1);
    test_bl8_crc_pad(1'b0);
    test_bl8_crc_pad(1'b1);
    test_timeout();
    test_false_start_overrun();
    test_enable_hold();
    test_reset_mid_burst();
    test_bl16_nocrc();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
